// File: rtl/alu_job_dispatcher.sv
// Job dispatcher for the two-unit ALU selector: buffers jobs in a FIFO, issues them
// one at a time through registered drive outputs and returns each result on a response port.

module alu_job_dispatcher_checker (
    input logic       clk,
    input logic       rst,
    input logic [1:0] request,
    input logic       rsp_valid,
    input logic       rsp_ready,
    input logic [3:0] rsp_data,
    input logic       rsp_ch
);
    // Both selector units must never be requested together
    a_no_dual_request: assert property (@(posedge clk) disable iff (rst) request != 2'b11);

    // A stalled response must hold its payload until accepted
    a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_ch)));
endmodule

module alu_job_dispatcher #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic             job_ch,
    input  logic [1:0]       job_op,
    input  logic [3:0]       job_a,
    input  logic [3:0]       job_b,
    output logic [3:0]       source_0,
    output logic [3:0]       source_1,
    output logic [3:0]       source_2,
    output logic [3:0]       source_3,
    output logic [1:0]       op_0,
    output logic [1:0]       op_1,
    output logic [1:0]       request,
    input  logic [3:0]       result_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_data,
    output logic             rsp_ch,
    output logic [CNT_W-1:0] done_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] s0;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [3:0] s3;
        logic [1:0] o0;
        logic [1:0] o1;
        logic [1:0] req;
        logic       ch;
    } drive_t;

    // Entry layout: {ch, op[1:0], a[3:0], b[3:0]}; the idle unit's fields stay zero
    function automatic drive_t load_drive(input logic [EW-1:0] e);
        drive_t d;
        d    = '0;
        d.ch = e[10];
        if (e[10] == 1'b0) begin
            d.s0  = e[7:4];
            d.s1  = e[3:0];
            d.o0  = e[9:8];
            d.req = 2'b01;
        end else begin
            d.s2  = e[7:4];
            d.s3  = e[3:0];
            d.o1  = e[9:8];
            d.req = 2'b10;
        end
        return d;
    endfunction

    logic [EW-1:0]    mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    state_t           state_r;
    drive_t           drive_r;
    logic             rsp_valid_r;
    logic [3:0]       rsp_data_r;
    logic             rsp_ch_r;
    logic [CNT_W-1:0] done_cnt_r;

    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic [EW-1:0]    head_s;

    assign full_s  = (count_r == (AW+1)'(DEPTH));
    assign empty_s = (count_r == (AW+1)'(0));
    assign push_s  = job_valid && !full_s;
    assign head_s  = mem_r[rd_ptr_r];

    // Pop decision: IDLE pops whenever work is queued, RESP only once the response is taken
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            ST_IDLE: pop_s = !empty_s;
            ST_RESP: pop_s = rsp_ready && !empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Job FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {job_ch, job_op, job_a, job_b};
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue FSM with registered drive and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            drive_r     <= '0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 4'd0;
            rsp_ch_r    <= 1'b0;
            done_cnt_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        drive_r <= load_drive(head_s);
                        state_r <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    rsp_data_r  <= result_in;
                    rsp_ch_r    <= drive_r.ch;
                    rsp_valid_r <= 1'b1;
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        done_cnt_r  <= done_cnt_r + CNT_W'(1);
                        rsp_valid_r <= 1'b0;
                        if (pop_s) begin
                            drive_r <= load_drive(head_s);
                            state_r <= ST_DRIVE;
                        end else begin
                            drive_r <= '0;
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    drive_r     <= '0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign job_ready = !full_s;
    assign source_0  = drive_r.s0;
    assign source_1  = drive_r.s1;
    assign source_2  = drive_r.s2;
    assign source_3  = drive_r.s3;
    assign op_0      = drive_r.o0;
    assign op_1      = drive_r.o1;
    assign request   = drive_r.req;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_ch    = rsp_ch_r;
    assign done_cnt  = done_cnt_r;

    alu_job_dispatcher_checker u_checker (
        .clk       (clk),
        .rst       (rst),
        .request   (request),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_ch    (rsp_ch)
    );
endmodule
